// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard, forwarding, freeze and flush controller for a 5-stage pipeline
//
// Purpose: generates the enables/flushes of the PC and the four pipeline
// registers, the EX operand forwarding selects, and a multi-cycle freeze
// while a load sits in MEM for MEM_LAT-1 cycles.
// Optional feature macro: HAZ_PERF_CNT_EN (stall/flush performance counters).
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   id_rs/id_rt/id_uses_*/id_jump ID-stage operands, qualifiers, jump flag
//   ex_rs/ex_rt/ex_dst/ex_valid/ex_memread   EX-stage instruction info
//   mem_dst/mem_valid/mem_regwrite/mem_memread/branch_taken  MEM-stage info
//   wb_dst/wb_regwrite            WB-stage writeback info
//   pc_en, *_en                   PC and pipeline-register load enables
//   if_id_flush, ex_mem_flush     pipeline-register clears
//   id_ex_bubble                  ID/EX loads a NOP
//   fwd_a, fwd_b                  EX operand mux selects (10=MEM, 01=WB, 00=RF)
//   stall_cnt, flush_cnt          performance counters (zero unless enabled)
module pipe_hazard_ctrl #(
    parameter int REG_AW        = 5,
    parameter int MEM_LAT       = 1,
    parameter int ZERO_REG_SKIP = 1,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_jump,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              ex_valid,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic              mem_valid,
    input  logic              mem_regwrite,
    input  logic              mem_memread,
    input  logic              branch_taken,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic              wb_regwrite,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_en,
    output logic              id_ex_bubble,
    output logic              ex_mem_en,
    output logic              ex_mem_flush,
    output logic              mem_wb_en,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam bit ZSKIP   = (ZERO_REG_SKIP != 0);
    localparam bit LAT_GT1 = (MEM_LAT > 1);
    localparam bit LAT_GT2 = (MEM_LAT > 2);
    // WAIT covers freeze cycles 2..MEM_LAT-1; the first freeze cycle is spent in RUN.
    localparam logic [3:0] WAIT_LD = 4'((MEM_LAT > 2) ? (MEM_LAT - 2) : 0);

    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       served_q, served_d;
    logic       lu_seen_q, lu_seen_d;

    logic mem_fwd_ok, wb_fwd_ok, ex_dst_ok;
    logic lu_raw, lu, frz_req, freeze, br;

    assign mem_fwd_ok = mem_regwrite && mem_valid && !(ZSKIP && mem_dst == '0);
    assign wb_fwd_ok  = wb_regwrite && !(ZSKIP && wb_dst == '0);
    assign ex_dst_ok  = !(ZSKIP && ex_dst == '0);

    assign lu_raw = ex_valid && ex_memread && ex_dst_ok &&
                    ((id_uses_rs && ex_dst == id_rs) || (id_uses_rt && ex_dst == id_rt));
    // The cycle after a load-use stall EX holds the bubble, so a still-visible
    // match is stale; masking it guarantees one bubble per hazard.
    assign lu      = lu_raw && !lu_seen_q;
    assign frz_req = LAT_GT1 && mem_valid && mem_memread && !served_q;
    assign freeze  = (state_q == ST_WAIT) || frz_req;
    assign br      = branch_taken && mem_valid;

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!rst) begin
            if (mem_fwd_ok && mem_dst == ex_rs)     fwd_a = 2'b10;
            else if (wb_fwd_ok && wb_dst == ex_rs)  fwd_a = 2'b01;
            if (mem_fwd_ok && mem_dst == ex_rt)     fwd_b = 2'b10;
            else if (wb_fwd_ok && wb_dst == ex_rt)  fwd_b = 2'b01;
        end
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_flush = 1'b0;
        if (rst) begin
            pc_en = 1'b1;
        end else if (freeze) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (br) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (lu) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (id_jump) begin
            if_id_flush = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        served_d  = served_q;
        lu_seen_d = freeze ? lu_seen_q : (lu && !br);
        case (state_q)
            ST_RUN: begin
                if (frz_req) begin
                    if (LAT_GT2) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LD;
                    end else begin
                        served_d = 1'b1;
                    end
                end else begin
                    // served only has to outlive the single release cycle
                    served_d = 1'b0;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d  = ST_RUN;
                    served_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            cnt_q     <= 4'd0;
            served_q  <= 1'b0;
            lu_seen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            served_q  <= served_d;
            lu_seen_q <= lu_seen_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (br && !freeze && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic       clk, rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
    logic       id_uses_rs, id_uses_rt, id_jump, ex_valid, ex_memread;
    logic       mem_valid, mem_regwrite, mem_memread, branch_taken, wb_regwrite;

    // en = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}; fl = {if_id_flush, id_ex_bubble, ex_mem_flush}
    logic [4:0]  en1, en4, en8;
    logic [2:0]  fl1, fl4, fl8;
    logic [1:0]  fa1, fb1, fa4, fb4, fa8, fb8;
    logic [15:0] sc1, fc1, sc4, fc4, sc8, fc8;

    int n_vec = 0;
    int n_err = 0;

    pipe_hazard_ctrl #(.MEM_LAT(1)) u1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_jump(id_jump), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_dst(ex_dst), .ex_valid(ex_valid), .ex_memread(ex_memread), .mem_dst(mem_dst),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .branch_taken(branch_taken), .wb_dst(wb_dst), .wb_regwrite(wb_regwrite),
        .pc_en(en1[4]), .if_id_en(en1[3]), .if_id_flush(fl1[2]), .id_ex_en(en1[2]),
        .id_ex_bubble(fl1[1]), .ex_mem_en(en1[1]), .ex_mem_flush(fl1[0]), .mem_wb_en(en1[0]),
        .fwd_a(fa1), .fwd_b(fb1), .stall_cnt(sc1), .flush_cnt(fc1));

    pipe_hazard_ctrl #(.MEM_LAT(4)) u4 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_jump(id_jump), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_dst(ex_dst), .ex_valid(ex_valid), .ex_memread(ex_memread), .mem_dst(mem_dst),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .branch_taken(branch_taken), .wb_dst(wb_dst), .wb_regwrite(wb_regwrite),
        .pc_en(en4[4]), .if_id_en(en4[3]), .if_id_flush(fl4[2]), .id_ex_en(en4[2]),
        .id_ex_bubble(fl4[1]), .ex_mem_en(en4[1]), .ex_mem_flush(fl4[0]), .mem_wb_en(en4[0]),
        .fwd_a(fa4), .fwd_b(fb4), .stall_cnt(sc4), .flush_cnt(fc4));

    pipe_hazard_ctrl #(.MEM_LAT(8)) u8 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_jump(id_jump), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_dst(ex_dst), .ex_valid(ex_valid), .ex_memread(ex_memread), .mem_dst(mem_dst),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .branch_taken(branch_taken), .wb_dst(wb_dst), .wb_regwrite(wb_regwrite),
        .pc_en(en8[4]), .if_id_en(en8[3]), .if_id_flush(fl8[2]), .id_ex_en(en8[2]),
        .id_ex_bubble(fl8[1]), .ex_mem_en(en8[1]), .ex_mem_flush(fl8[0]), .mem_wb_en(en8[0]),
        .fwd_a(fa8), .fwd_b(fb8), .stall_cnt(sc8), .flush_cnt(fc8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0; ex_dst = 5'd0;
        mem_dst = 5'd0; wb_dst = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_jump = 1'b0; ex_valid = 1'b0; ex_memread = 1'b0; mem_valid = 1'b0;
        mem_regwrite = 1'b0; mem_memread = 1'b0; branch_taken = 1'b0; wb_regwrite = 1'b0;
    endtask

    // inputs change at the falling edge, outputs are sampled 2 ns later
    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        mem_valid = 1'b1; mem_regwrite = 1'b1; mem_memread = 1'b1; mem_dst = 5'd3;
        ex_rs = 5'd3; ex_rt = 5'd3; branch_taken = 1'b1; id_jump = 1'b1;
        #2;
        n_vec++; if (en4 !== 5'b11111) begin n_err++; $display("FAIL reset_en got=%b exp=%b", en4, 5'b11111); end
        n_vec++; if (fl4 !== 3'b000) begin n_err++; $display("FAIL reset_fl got=%b exp=%b", fl4, 3'b000); end
        n_vec++; if (fa4 !== 2'b00 || fb4 !== 2'b00) begin n_err++; $display("FAIL reset_fwd got=%b/%b exp=00/00", fa4, fb4); end
        n_vec++; if (sc4 !== 16'd0 || fc4 !== 16'd0) begin n_err++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", sc4, fc4); end
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        clear_inputs();
        ex_rs = 5'd3; ex_rt = 5'd3; mem_dst = 5'd3; mem_regwrite = 1'b1; mem_valid = 1'b1;
        wb_dst = 5'd3; wb_regwrite = 1'b1;
        #2;
        n_vec++; if (fa1 !== 2'b10) begin n_err++; $display("FAIL fwd_mem_prio got=%b exp=%b", fa1, 2'b10); end
        n_vec++; if (fb1 !== 2'b10) begin n_err++; $display("FAIL fwdb_mem_prio got=%b exp=%b", fb1, 2'b10); end
        @(negedge clk);
        mem_regwrite = 1'b0;
        #2;
        n_vec++; if (fa1 !== 2'b01) begin n_err++; $display("FAIL fwd_wb got=%b exp=%b", fa1, 2'b01); end
        @(negedge clk);
        mem_regwrite = 1'b1; mem_valid = 1'b0; ex_rt = 5'd7;
        #2;
        n_vec++; if (fa1 !== 2'b01) begin n_err++; $display("FAIL fwd_mem_invalid got=%b exp=%b", fa1, 2'b01); end
        n_vec++; if (fb1 !== 2'b00) begin n_err++; $display("FAIL fwdb_nomatch got=%b exp=%b", fb1, 2'b00); end
        @(negedge clk);
        mem_valid = 1'b1; ex_rs = 5'd0; ex_rt = 5'd0; mem_dst = 5'd0; wb_dst = 5'd0;
        #2;
        n_vec++; if (fa1 !== 2'b00 || fb1 !== 2'b00) begin n_err++; $display("FAIL fwd_zero got=%b/%b exp=00/00", fa1, fb1); end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        clear_inputs();
        ex_valid = 1'b1; ex_memread = 1'b1; ex_dst = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
        #2;
        n_vec++; if (en1 !== 5'b00111) begin n_err++; $display("FAIL lu_stall_en got=%b exp=%b", en1, 5'b00111); end
        n_vec++; if (fl1 !== 3'b010) begin n_err++; $display("FAIL lu_stall_fl got=%b exp=%b", fl1, 3'b010); end
        // the bubble now occupies EX
        @(negedge clk);
        ex_valid = 1'b0; ex_memread = 1'b0; ex_dst = 5'd0;
        #2;
        n_vec++; if (en1 !== 5'b11111 || fl1 !== 3'b000) begin n_err++; $display("FAIL lu_one_cycle got=%b/%b exp=11111/000", en1, fl1); end
        @(negedge clk);
        ex_valid = 1'b1; ex_memread = 1'b1; ex_dst = 5'd5; id_uses_rs = 1'b0;
        #2;
        n_vec++; if (en1 !== 5'b11111 || fl1 !== 3'b000) begin n_err++; $display("FAIL lu_unused_rs got=%b/%b exp=11111/000", en1, fl1); end
        @(negedge clk);
        id_rt = 5'd5; id_uses_rt = 1'b1;
        #2;
        n_vec++; if (en1 !== 5'b00111 || fl1 !== 3'b010) begin n_err++; $display("FAIL lu_rt got=%b/%b exp=00111/010", en1, fl1); end
        @(negedge clk);
        clear_inputs();
        ex_valid = 1'b1; ex_memread = 1'b1; id_uses_rs = 1'b1;
        #2;
        n_vec++; if (en1 !== 5'b11111) begin n_err++; $display("FAIL lu_zero_dst got=%b exp=%b", en1, 5'b11111); end
    endtask

    task automatic test_freeze();
        do_reset();
        mem_valid = 1'b1; mem_memread = 1'b1; mem_regwrite = 1'b1; mem_dst = 5'd9;
        #2;
        n_vec++; if (en1 !== 5'b11111) begin n_err++; $display("FAIL frz_lat1 got=%b exp=%b", en1, 5'b11111); end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin @(negedge clk); #2; end
            n_vec++; if (en4 !== 5'b00000) begin n_err++; $display("FAIL frz_cycle%0d got=%b exp=%b", i, en4, 5'b00000); end
        end
        @(negedge clk);
        #2;
        n_vec++; if (en4 !== 5'b11111) begin n_err++; $display("FAIL frz_release got=%b exp=%b", en4, 5'b11111); end
        @(negedge clk);
        mem_memread = 1'b0; mem_dst = 5'd4;
        #2;
        n_vec++; if (en4 !== 5'b11111) begin n_err++; $display("FAIL frz_no_refreeze got=%b exp=%b", en4, 5'b11111); end
        n_vec++; if (sc4 !== (PERF ? 16'd3 : 16'd0)) begin n_err++; $display("FAIL frz_stall_cnt got=%0d exp=%0d", sc4, PERF ? 3 : 0); end
    endtask

    task automatic test_branch_lu();
        do_reset();
        branch_taken = 1'b1; mem_valid = 1'b1;
        ex_valid = 1'b1; ex_memread = 1'b1; ex_dst = 5'd6; id_rs = 5'd6; id_uses_rs = 1'b1;
        #2;
        n_vec++; if (fl1 !== 3'b111) begin n_err++; $display("FAIL br_flush got=%b exp=%b", fl1, 3'b111); end
        n_vec++; if (en1[4] !== 1'b1) begin n_err++; $display("FAIL br_pc_en got=%b exp=1", en1[4]); end
        @(negedge clk);
        clear_inputs();
        #2;
        n_vec++; if (sc1 !== 16'd0) begin n_err++; $display("FAIL br_stall_cnt got=%0d exp=0", sc1); end
        n_vec++; if (fc1 !== (PERF ? 16'd1 : 16'd0)) begin n_err++; $display("FAIL br_flush_cnt got=%0d exp=%0d", fc1, PERF ? 1 : 0); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        mem_valid = 1'b1; mem_memread = 1'b1; mem_dst = 5'd2;
        #2;
        n_vec++; if (en8 !== 5'b00000) begin n_err++; $display("FAIL rmw_frz1 got=%b exp=%b", en8, 5'b00000); end
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_vec++; if (en8 !== 5'b11111 || fl8 !== 3'b000) begin n_err++; $display("FAIL rmw_async got=%b/%b exp=11111/000", en8, fl8); end
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            #2;
            n_vec++; if (en8 !== 5'b11111) begin n_err++; $display("FAIL rmw_after%0d got=%b exp=%b", i, en8, 5'b11111); end
            @(negedge clk);
        end
    endtask

    task automatic test_jump();
        clear_inputs();
        id_jump = 1'b1;
        #2;
        n_vec++; if (en1 !== 5'b11111 || fl1 !== 3'b100) begin n_err++; $display("FAIL jump_alone got=%b/%b exp=11111/100", en1, fl1); end
        @(negedge clk);
        ex_valid = 1'b1; ex_memread = 1'b1; ex_dst = 5'd8; id_rt = 5'd8; id_uses_rt = 1'b1;
        #2;
        n_vec++; if (en1 !== 5'b00111 || fl1 !== 3'b010) begin n_err++; $display("FAIL jump_lu got=%b/%b exp=00111/010", en1, fl1); end
        @(negedge clk);
        ex_valid = 1'b0; ex_memread = 1'b0; ex_dst = 5'd0;
        #2;
        n_vec++; if (fl1 !== 3'b100) begin n_err++; $display("FAIL jump_retry got=%b exp=%b", fl1, 3'b100); end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_freeze();
        test_branch_lu();
        test_reset_mid_wait();
        test_jump();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
